// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: owns the PC, runs one imem request at a time and
// hands each fetched word to decode over a valid/ready handshake.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4,
    parameter int                    TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  halt_req,
    output logic                  halted,
    output logic                  fault
);

    localparam int                    CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      TCNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP_INC  = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] STEP_MASK = ADDR_WIDTH'(PC_STEP - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4,
        FAULT  = 3'd5
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
    logic [ADDR_WIDTH-1:0]   drain_addr_reg, drain_addr_next;
    logic [DATA_WIDTH-1:0]   inst_out_reg, inst_out_next;
    logic [ADDR_WIDTH-1:0]   inst_pc_reg, inst_pc_next;
    logic [CNT_W-1:0]        tcnt_reg, tcnt_next;
    logic                    halted_reg, halted_next;
    logic                    fault_reg, fault_next;
    logic [ADDR_WIDTH-1:0]   target_masked;

    // Redirect targets are forced onto an instruction boundary.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_mask
            assign target_masked[gi] = redirect_target[gi] & ~STEP_MASK[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            drain_addr_reg <= '0;
            inst_out_reg   <= '0;
            inst_pc_reg    <= '0;
            tcnt_reg       <= '0;
            halted_reg     <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            drain_addr_reg <= drain_addr_next;
            inst_out_reg   <= inst_out_next;
            inst_pc_reg    <= inst_pc_next;
            tcnt_reg       <= tcnt_next;
            halted_reg     <= halted_next;
            fault_reg      <= fault_next;
        end
    end

    // Counter defaults to zero so every entry into FETCH/DRAIN starts a fresh
    // wait window; it only advances while a request sits unanswered.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        drain_addr_next = drain_addr_reg;
        inst_out_next   = inst_out_reg;
        inst_pc_next    = inst_pc_reg;
        tcnt_next       = '0;

        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end

            FETCH: begin
                if (redirect_valid) begin
                    pc_next = target_masked;
                    if (imem_ack) begin
                        state_next = FETCH;
                    end else begin
                        // Request is still outstanding at the old address.
                        state_next      = DRAIN;
                        drain_addr_next = pc_reg;
                    end
                end else if (imem_ack) begin
                    inst_out_next = imem_rdata;
                    inst_pc_next  = pc_reg;
                    state_next    = ISSUE;
                end else if (tcnt_reg == TCNT_LAST) begin
                    state_next = FAULT;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end

            ISSUE: begin
                if (redirect_valid) begin
                    pc_next    = target_masked;
                    state_next = FETCH;
                end else if (inst_ready) begin
                    if (halt_req) begin
                        state_next = HALTED;
                    end else begin
                        pc_next    = pc_reg + STEP_INC;
                        state_next = FETCH;
                    end
                end
            end

            DRAIN: begin
                if (redirect_valid) begin
                    pc_next = target_masked;
                end
                if (imem_ack) begin
                    state_next = FETCH;
                end else if (tcnt_reg == TCNT_LAST) begin
                    state_next = FAULT;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end

            HALTED: state_next = HALTED;
            FAULT:  state_next = FAULT;
            default: state_next = IDLE;
        endcase

        halted_next = halted_reg | (state_next == HALTED);
        fault_next  = fault_reg  | (state_next == FAULT);
    end

    assign imem_req   = (state_reg == FETCH) || (state_reg == DRAIN);
    assign imem_addr  = (state_reg == DRAIN) ? drain_addr_reg : pc_reg;
    assign inst_valid = (state_reg == ISSUE);
    assign inst_out   = inst_out_reg;
    assign inst_pc    = inst_pc_reg;
    assign halted     = halted_reg;
    assign fault      = fault_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: hand-computed expectations checked with
// immediate assertions, one line per miscompare and a single summary line.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        halted;
    logic        fault;

    int n_vec;
    int n_err;

    fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_out        (inst_out),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .halted          (halted),
        .fault           (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs set here are seen at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Serve one fetch with the ack one cycle after the request appears.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, a);
        chk("fetch_novalid", {31'd0, inst_valid}, 32'd0);
        step();
        chk("fetch_req_hold", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr_hold", imem_addr, a);
        imem_ack   = 1'b1;
        imem_rdata = d;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        chk("issue_valid", {31'd0, inst_valid}, 32'd1);
        chk("issue_out", inst_out, d);
        chk("issue_pc", inst_pc, a);
        chk("issue_noreq", {31'd0, imem_req}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = '0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        halt_req = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_out", inst_out, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        reset = 1'b0;
        step();

        // Sequential fetch 0,4,8,12 with decode always ready
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_fetch(32'(i * 4), 32'hA000_0000 + 32'(i));
            step();
        end

        // Decode stall: issued word held, no new request
        inst_ready = 1'b0;
        do_fetch(32'h10, 32'hB0B0_0010);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_out", inst_out, 32'hB0B0_0010);
            chk("stall_pc", inst_pc, 32'h10);
            chk("stall_noreq", {31'd0, imem_req}, 32'd0);
        end
        inst_ready = 1'b1;
        step();
        chk("after_stall_addr", imem_addr, 32'h14);

        // Redirect during FETCH without ack -> DRAIN at old address
        redirect_valid  = 1'b1;
        redirect_target = 32'h103;
        step();
        redirect_valid = 1'b0;
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'h14);
        chk("drain_novalid", {31'd0, inst_valid}, 32'd0);
        step();
        chk("drain_addr2", imem_addr, 32'h14);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("post_drain_valid", {31'd0, inst_valid}, 32'd0);
        chk("post_drain_addr", imem_addr, 32'h100);

        // Redirect + ready + halt_req at ISSUE: redirect wins, no halt
        do_fetch(32'h100, 32'hC0DE_0100);
        inst_ready      = 1'b1;
        halt_req        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        step();
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        chk("redir_issue_halted", {31'd0, halted}, 32'd0);
        chk("redir_issue_addr", imem_addr, 32'h40);
        chk("redir_issue_req", {31'd0, imem_req}, 32'd1);

        // Redirect with ack in the same FETCH cycle: data dropped, refetch
        imem_ack        = 1'b1;
        imem_rdata      = 32'h1111_1111;
        redirect_valid  = 1'b1;
        redirect_target = 32'h81;
        step();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        chk("redir_ack_valid", {31'd0, inst_valid}, 32'd0);
        chk("redir_ack_addr", imem_addr, 32'h80);
        do_fetch(32'h80, 32'hD0D0_0080);
        step();
        chk("seq_after_redir", imem_addr, 32'h84);

        // Halt at the handshake of pc 0x10
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            do_fetch(32'(i * 4), 32'h5000_0000 + 32'(i));
            step();
        end
        do_fetch(32'h10, 32'hE0E0_0010);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_noreq", {31'd0, imem_req}, 32'd0);
        chk("halt_novalid", {31'd0, inst_valid}, 32'd0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        step();
        redirect_valid = 1'b0;
        chk("halt_sticky", {31'd0, halted}, 32'd1);
        chk("halt_pc_kept", imem_addr, 32'h10);
        reset = 1'b1;
        step();
        chk("halt_cleared", {31'd0, halted}, 32'd0);
        reset = 1'b0;
        step();

        // No ack for 15 cycles -> FAULT
        for (int k = 1; k <= 15; k++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_nofault", {31'd0, fault}, 32'd0);
            step();
        end
        chk("timeout_fault", {31'd0, fault}, 32'd1);
        chk("timeout_noreq", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        chk("fault_noreq", {31'd0, imem_req}, 32'd0);

        // Ack on the 15th waiting cycle is honoured
        reset = 1'b1;
        step();
        chk("fault_cleared", {31'd0, fault}, 32'd0);
        reset = 1'b0;
        step();
        for (int k = 1; k <= 14; k++) step();
        imem_ack   = 1'b1;
        imem_rdata = 32'h5A5A_0000;
        step();
        imem_ack = 1'b0;
        chk("late_ack_nofault", {31'd0, fault}, 32'd0);
        chk("late_ack_valid", {31'd0, inst_valid}, 32'd1);
        chk("late_ack_out", inst_out, 32'h5A5A_0000);

        // Reset during DRAIN, then a stray ack in IDLE is ignored
        inst_ready = 1'b1;
        step();
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        step();
        redirect_valid = 1'b0;
        chk("mid_drain_addr", imem_addr, 32'h4);
        reset = 1'b1;
        step();
        chk("rst_drain_noreq", {31'd0, imem_req}, 32'd0);
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0099;
        step();
        imem_ack = 1'b0;
        chk("stray_req", {31'd0, imem_req}, 32'd1);
        chk("stray_addr", imem_addr, 32'h0);
        step();
        chk("stray_still_fetch", {31'd0, imem_req}, 32'd1);
        chk("stray_novalid", {31'd0, inst_valid}, 32'd0);

        // PC wrap: masked target 0xFFFFFFFC, then +4 wraps to 0
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        do_fetch(32'hFFFF_FFFC, 32'h7777_7777);
        step();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_req", {31'd0, imem_req}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
